// File: rtl/fifo_feed_ctrl.sv
// fifo_feed_ctrl: loads one tile of L*ARRAY_SIZE elements round-robin into a
// bank of row fifos, then drains the bank with a one-cycle-per-row skew so the
// systolic array sees a diagonal wavefront.
//
//  state | meaning
//  IDLE  | waiting for a start with a legal tile length
//  CLR   | one-cycle clear pulse to the fifo bank
//  LOAD  | accept upstream elements, fifo wsel gets the next one
//  DRAIN | skewed read enables, counter c runs 0..L+ARRAY_SIZE-2
//  FIN   | one-cycle done pulse
module fifo_feed_ctrl #(
    parameter int ARRAY_SIZE = 9,
    parameter int data_size  = 8,
    parameter int fifo_depth = 256
) (
    input  logic                  s_clk_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [8:0]            num_rows_i,
    input  logic                  in_valid_i,
    input  logic [data_size-1:0]  in_data_i,
    output logic                  in_ready_o,
    input  logic [ARRAY_SIZE-1:0] fifo_full_i,
    input  logic [ARRAY_SIZE-1:0] fifo_empty_i,
    output logic                  fifo_clear_o,
    output logic [ARRAY_SIZE-1:0] fifo_w_en_o,
    output logic [data_size-1:0]  fifo_data_o,
    output logic [ARRAY_SIZE-1:0] fifo_r_en_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int WSW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    // wide enough for the drain counter's last value, L+ARRAY_SIZE-2
    localparam int CW  = $clog2(fifo_depth + ARRAY_SIZE);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        LOAD  = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t          state_q;
    logic [WSW-1:0]  wsel_q;
    logic [CW-1:0]   row_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   len_q;
    logic            err_q;

    logic            start_ok;
    logic            accept;
    logic            wsel_last;
    logic            row_last;
    logic            cnt_last;
    logic            underflow;
    logic            err_d;

    // Tile-length legality and counter terminal compares
    always_comb begin
        start_ok  = start_i && (num_rows_i != 9'd0) && (int'(num_rows_i) <= fifo_depth);
        wsel_last = (int'(wsel_q) == ARRAY_SIZE - 1);
        row_last  = (row_q == len_q - CW'(1));
        cnt_last  = (int'(cnt_q) == int'(len_q) + ARRAY_SIZE - 2);
    end

    // Write path: zero-latency handshake straight into the selected fifo
    always_comb begin
        in_ready_o  = (state_q == LOAD) && !fifo_full_i[wsel_q];
        accept      = in_valid_i && in_ready_o;
        fifo_w_en_o = accept ? (ARRAY_SIZE'(1) << wsel_q) : '0;
        fifo_data_o = (state_q == LOAD) ? in_data_i : '0;
    end

    // Read path: fifo k is read during the L-cycle window starting at c=k
    always_comb begin
        fifo_r_en_o = '0;
        for (int k = 0; k < ARRAY_SIZE; k++) begin
            fifo_r_en_o[k] = (state_q == DRAIN) && (int'(cnt_q) >= k) &&
                             (int'(cnt_q) < k + int'(len_q));
        end
        underflow = |(fifo_r_en_o & fifo_empty_i);
    end

    // Sticky underflow flag: cleared only by an accepted start
    always_comb begin
        err_d = err_q;
        if (state_q == IDLE && start_ok) begin
            err_d = 1'b0;
        end else if (state_q == DRAIN && underflow) begin
            err_d = 1'b1;
        end
    end

    // Status outputs decode straight from the state register
    always_comb begin
        busy_o       = (state_q != IDLE);
        done_o       = (state_q == FIN);
        fifo_clear_o = (state_q == CLR);
        err_o        = err_q;
    end

    // Tile sequencer
    always_ff @(posedge s_clk_i or posedge clear_i) begin
        if (clear_i) begin
            state_q <= IDLE;
            wsel_q  <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= err_d;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        len_q   <= CW'(num_rows_i);
                        wsel_q  <= '0;
                        row_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= CLR;
                    end
                end
                CLR: begin
                    wsel_q  <= '0;
                    row_q   <= '0;
                    state_q <= LOAD;
                end
                LOAD: begin
                    if (accept) begin
                        if (wsel_last) begin
                            wsel_q <= '0;
                            if (row_last) begin
                                cnt_q   <= '0;
                                state_q <= DRAIN;
                            end else begin
                                row_q <= row_q + CW'(1);
                            end
                        end else begin
                            wsel_q <= wsel_q + WSW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_last) begin
                        state_q <= FIN;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_feed_ctrl.sv
// Bench for fifo_feed_ctrl: per-tile reference model driven by accepted-element
// count and drain cycle index rather than the controller's own counters.
module tb_fifo_feed_ctrl;

    localparam int A  = 9;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          clear;
    logic          start;
    logic [8:0]    num_rows;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [A-1:0]  fifo_full;
    logic [A-1:0]  fifo_empty;
    logic          fifo_clear;
    logic [A-1:0]  fifo_w_en;
    logic [DW-1:0] fifo_data;
    logic [A-1:0]  fifo_r_en;
    logic          busy;
    logic          done;
    logic          err;

    int total = 0;
    int bad   = 0;
    bit exp_err = 1'b0;

    fifo_feed_ctrl #(.ARRAY_SIZE(A), .data_size(DW), .fifo_depth(256)) dut (
        .s_clk_i      (clk),
        .clear_i      (clear),
        .start_i      (start),
        .num_rows_i   (num_rows),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready),
        .fifo_full_i  (fifo_full),
        .fifo_empty_i (fifo_empty),
        .fifo_clear_o (fifo_clear),
        .fifo_w_en_o  (fifo_w_en),
        .fifo_data_o  (fifo_data),
        .fifo_r_en_o  (fifo_r_en),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_err"},   32'(err), 0);
        chk({tag, "_rdy"},   32'(in_ready), 0);
        chk({tag, "_clr"},   32'(fifo_clear), 0);
        chk({tag, "_wen"},   32'(fifo_w_en), 0);
        chk({tag, "_ren"},   32'(fifo_r_en), 0);
        chk({tag, "_data"},  32'(fifo_data), 0);
    endtask

    // One full tile. data_base<0 means random data; full_mode 0 none,
    // 1 random, 2 fifo 2 held full for 4 cycles; empty_k<0 means no underflow;
    // abort_at>=0 pulses clear once that many elements have been accepted.
    task automatic run_tile(input int L, input bit rand_valid, input int data_base,
                            input int full_mode, input int empty_k,
                            input int abort_at, input bit poke_start);
        int n;
        int guard;
        int stall_left;
        int ws;
        bit exp_rdy;
        bit acc;
        logic [A-1:0] exp_ren;

        @(negedge clk);
        start = 1'b1; num_rows = 9'(L); in_valid = 1'b0;
        fifo_full = '0; fifo_empty = '0;
        #1;
        chk("start_busy", 32'(busy), 0);
        chk("start_err",  32'(err), 32'(exp_err));

        @(negedge clk);
        start = 1'b0;
        exp_err = 1'b0;
        #1;
        chk("clr_pulse", 32'(fifo_clear), 1);
        chk("clr_busy",  32'(busy), 1);
        chk("clr_rdy",   32'(in_ready), 0);
        chk("clr_wen",   32'(fifo_w_en), 0);
        chk("clr_err",   32'(err), 0);

        n = 0; guard = 0; stall_left = 4;
        while (n < L * A) begin
            @(negedge clk);
            if (abort_at >= 0 && n == abort_at) begin
                clear = 1'b1;
                in_valid = 1'b1;
                in_data = 8'hA5;
                #1;
                chk_reset_outputs("abort");
                @(negedge clk);
                clear = 1'b0;
                in_valid = 1'b0;
                exp_err = 1'b0;
                #1;
                chk("abort_idle_busy", 32'(busy), 0);
                return;
            end
            start = 1'b0;
            if (poke_start && n == 3) begin
                start = 1'b1;
                num_rows = 9'(L + 1);
            end
            ws = n % A;
            in_valid = rand_valid ? 1'($urandom_range(1)) : 1'b1;
            in_data = (data_base >= 0) ? DW'(data_base + n) : DW'($urandom);
            fifo_full = '0;
            if (full_mode == 1 && $urandom_range(3) == 0) begin
                fifo_full = A'($urandom);
            end else if (full_mode == 2 && ws == 2 && stall_left > 0) begin
                fifo_full = A'(1) << 2;
                stall_left--;
            end
            #1;
            exp_rdy = !fifo_full[ws];
            acc = in_valid && exp_rdy;
            chk("load_rdy",  32'(in_ready), 32'(exp_rdy));
            chk("load_wen",  32'(fifo_w_en), acc ? (32'(1) << ws) : 0);
            chk("load_data", 32'(fifo_data), 32'(in_data));
            chk("load_busy", 32'(busy), 1);
            chk("load_ren",  32'(fifo_r_en), 0);
            chk("load_clr",  32'(fifo_clear), 0);
            if (acc) n++;
            guard++;
            if (guard > 5000) begin
                chk("load_timeout", 32'(n), 32'(L * A));
                break;
            end
        end

        for (int d = 0; d <= L + A - 2; d++) begin
            @(negedge clk);
            start = 1'b0;
            in_valid = 1'($urandom_range(1));
            fifo_full = A'($urandom);
            fifo_empty = (empty_k >= 0 && empty_k < A) ? (A'(1) << empty_k) : '0;
            #1;
            for (int k = 0; k < A; k++) exp_ren[k] = (d >= k) && (d < k + L);
            chk("drain_ren",  32'(fifo_r_en), 32'(exp_ren));
            chk("drain_rdy",  32'(in_ready), 0);
            chk("drain_wen",  32'(fifo_w_en), 0);
            chk("drain_busy", 32'(busy), 1);
            chk("drain_done", 32'(done), 0);
            chk("drain_err",  32'(err), 32'(exp_err));
            if ((exp_ren & fifo_empty) != '0) exp_err = 1'b1;
        end

        @(negedge clk);
        fifo_empty = '0; in_valid = 1'b0;
        #1;
        chk("fin_done", 32'(done), 1);
        chk("fin_busy", 32'(busy), 1);
        chk("fin_ren",  32'(fifo_r_en), 0);
        chk("fin_err",  32'(err), 32'(exp_err));

        @(negedge clk);
        #1;
        chk("idle_done", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_err",  32'(err), 32'(exp_err));
    endtask

    task automatic bad_start(input logic [8:0] nr);
        @(negedge clk);
        start = 1'b1; num_rows = nr;
        #1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("ign_busy", 32'(busy), 0);
        chk("ign_clr",  32'(fifo_clear), 0);
        chk("ign_err",  32'(err), 32'(exp_err));
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; num_rows = '0;
        in_valid = 1'b1; in_data = 8'h5A;
        fifo_full = '0; fifo_empty = '0;
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset_outputs("reset_held");
        clear = 1'b0;
        in_valid = 1'b0;

        run_tile(1, 1'b0, 1, 0, -1, -1, 1'b0);
        run_tile(3, 1'b0, 0, 0, -1, -1, 1'b0);
        bad_start(9'd0);
        bad_start(9'd257);
        run_tile(2, 1'b1, -1, 2, -1, -1, 1'b1);
        run_tile(4, 1'b1, -1, 1, -1, -1, 1'b0);
        run_tile(3, 1'b0, 0, 0, -1, 5, 1'b0);
        run_tile(1, 1'b0, 1, 0, -1, -1, 1'b0);
        run_tile(2, 1'b0, -1, 0, 4, -1, 1'b0);
        bad_start(9'd0);
        run_tile(256, 1'b0, -1, 0, -1, -1, 1'b0);
        for (int t = 0; t < 4; t++) begin
            run_tile($urandom_range(1, 6), 1'b1, -1, 1,
                     $urandom_range(0, 2 * A), -1, 1'($urandom_range(1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_feed_ctrl.md
FIFO_FEED_CTRL -- requirements
Module: fifo_feed_ctrl

Interface
REQ-001 Parameter ARRAY_SIZE, default 9, number of fifo instances in the bank, one per systolic-array row.
REQ-002 Parameter data_size, default 8, element width.
REQ-003 Parameter fifo_depth, default 256, depth of each fifo.
REQ-004 s_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 clear  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle request to run one load+drain tile.
REQ-007 num_rows  in  9  tile length L, meaning elements per fifo, valid 1..fifo_depth.
REQ-008 in_valid  in  1  upstream element valid.
REQ-009 in_data  in  data_size  upstream element.
REQ-010 in_ready  out  1  element accepted when in_valid and in_ready are both high.
REQ-011 fifo_full  in  ARRAY_SIZE  per-fifo full flags.
REQ-012 fifo_empty  in  ARRAY_SIZE  per-fifo empty flags.
REQ-013 fifo_clear  out  1  clear pulse to the fifo bank.
REQ-014 fifo_w_en  out  ARRAY_SIZE  one-hot write enables.
REQ-015 fifo_data  out  data_size  shared fifo write data.
REQ-016 fifo_r_en  out  ARRAY_SIZE  skewed read enables.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle tile-complete pulse.
REQ-019 err  out  1  sticky underflow flag.

Function
REQ-020 FSM states: IDLE, CLR, LOAD, DRAIN, FIN.
REQ-021 IDLE: start=1 with num_rows in 1..fifo_depth latches L, clears err, and moves to CLR. Any other start is ignored and the FSM stays in IDLE.
REQ-022 start while busy=1 is ignored, with no effect on state or latched L.
REQ-023 CLR: lasts exactly 1 cycle; fifo_clear=1; then moves to LOAD. fifo_clear=0 in all other states.
REQ-024 LOAD counters: write select wsel (0..ARRAY_SIZE-1) and row counter (0..L-1), both 0 on entry.
REQ-025 LOAD in_ready: in_ready = (state==LOAD) and !fifo_full[wsel]. in_ready=0 in all other states.
REQ-026 LOAD write path is combinational and zero-latency: fifo_w_en = onehot(wsel) gated by accept; fifo_data = in_data.
REQ-027 LOAD on accept: wsel increments, wrapping ARRAY_SIZE-1 to 0; the row counter increments on each wrap.
REQ-028 LOAD exit: the accept with wsel=ARRAY_SIZE-1 and row=L-1 is the final write; the next state is DRAIN. Total accepts = L*ARRAY_SIZE.
REQ-029 DRAIN cycle counter: c, 0 on entry, runs 0..L+ARRAY_SIZE-2, so DRAIN lasts L+ARRAY_SIZE-1 cycles.
REQ-030 DRAIN read enables: fifo_r_en[k] = (k <= c < k+L). This is combinational from c and state; fifo_r_en=0 outside DRAIN.
REQ-031 DRAIN underflow: fifo_r_en[k]=1 while fifo_empty[k]=1 sets err=1 in the next cycle. The read enable is still issued.
REQ-032 FIN: lasts 1 cycle; done=1; then moves to IDLE.
REQ-033 Arithmetic: counters are sized for L+ARRAY_SIZE-1 and never overflow; num_rows above fifo_depth is rejected per REQ-021.

Reset
REQ-034 While clear=1, regardless of s_clk: state=IDLE and all counters=0.
REQ-035 While clear=1, outputs are: busy=0, done=0, err=0, in_ready=0, fifo_clear=0, fifo_w_en=0, fifo_r_en=0, fifo_data=0.
REQ-036 Reset asserted mid-LOAD or mid-DRAIN abandons the tile. Stale fifo contents are removed by the CLR state of the next tile.

Verification
REQ-037 L=1, in_valid held 1, data 0x01..0x09 -> fifo_clear pulses 1 cycle. fifo_w_en walks 0x001..0x100 with fifo_data 0x01..0x09. DRAIN lasts 9 cycles with fifo_r_en[k] high only at c=k. done pulses once.
REQ-038 L=3, 27 elements 0x00..0x1A -> element 0x09 is written to fifo 0 and element 0x1A to fifo 8. fifo_r_en[0] is high at c=0..2 and fifo_r_en[8] at c=8..10. DRAIN lasts 11 cycles.
REQ-039 fifo_full[2]=1 for 4 cycles when wsel=2 -> in_ready=0 and fifo_w_en=0 for those cycles. Resumes at wsel=2 with no element lost or duplicated.
REQ-040 start pulsed during LOAD, and start with num_rows=0 or 257 in IDLE -> no state change. Latched L is unchanged.
REQ-041 clear pulsed mid-LOAD after 5 accepts -> outputs are at reset values immediately. A following start with L=1 runs a full clean tile.
REQ-042 fifo_empty[4] forced 1 during DRAIN with L=2 -> err=1 from the cycle after c=4 until the next accepted start.
